// File: rtl/mfp_seven_segment_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mfp_seven_segment_scanner                                     |
// | Purpose  : Time-multiplexed driver for an N-digit common-anode 7-segment |
// |            display. Takes one hex nibble per digit, snapshots the whole  |
// |            frame at the frame boundary, and scans the digits with a      |
// |            blank guard interval at the start of each digit slot.         |
// | Ports    : HCLK      - clock                                             |
// |            HRESETn   - asynchronous active-low reset                     |
// |            hex_in    - 4*N_DIGITS nibbles, nibble k drives digit k       |
// |            anodes    - registered one-hot digit enable (output polarity) |
// |            segments  - registered segment bus, bit0=a .. bit6=g          |
// | Options  : MFP_SEVEN_SEG_LZB_EN - when defined, leading-zero blanking   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mfp_seven_segment_scanner #(
  parameter int N_DIGITS   = 8,
  parameter int SCAN_DIV_W = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [4*N_DIGITS-1:0]   hex_in,
  output logic [N_DIGITS-1:0]     anodes,
  output logic [6:0]              segments
);

  localparam int                 DW         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DW-1:0]      LAST_DIGIT = DW'(N_DIGITS - 1);
  localparam logic               INV        = (ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] ANODE_OFF = {N_DIGITS{INV}};
  localparam logic [6:0]         SEG_OFF    = {7{INV}};

  logic [SCAN_DIV_W-1:0] p_q, p_d;
  logic [DW-1:0]         d_q, d_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [N_DIGITS-1:0]   anodes_q, anodes_d;
  logic [6:0]            segments_q, segments_d;

  logic       slot_end;
  logic       frame_end;
  logic       guard;
  logic       blank;
  logic [3:0] nib [N_DIGITS];

  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  generate
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_nib
      assign nib[k] = shadow_q[4*k +: 4];
    end
  endgenerate

  assign slot_end  = &p_q;
  assign frame_end = slot_end && (d_q == LAST_DIGIT);
  // Guard is the first eighth of the slot: top three prescaler bits all zero.
  assign guard     = (p_q[SCAN_DIV_W-1 -: 3] == 3'b000);

`ifdef MFP_SEVEN_SEG_LZB_EN
  // lz[k] is set when nibbles k..N_DIGITS-1 of the snapshot are all zero.
  logic [N_DIGITS-1:0] lz;
  generate
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_lz
      assign lz[k] = ~|shadow_q[4*N_DIGITS-1:4*k];
    end
  endgenerate
  assign blank = (d_q != '0) && lz[d_q];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    p_d        = p_q + 1'b1;
    d_d        = d_q;
    shadow_d   = shadow_q;
    anodes_d   = '0;
    segments_d = '0;

    if (slot_end) begin
      d_d = (d_q == LAST_DIGIT) ? '0 : d_q + 1'b1;
    end
    // Snapshot taken in the same cycle the digit index wraps, so a frame
    // never mixes old and new hex values.
    if (frame_end) begin
      shadow_d = hex_in;
    end

    if (!guard) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        anodes_d[k] = (d_q == DW'(k));
      end
      segments_d = blank ? 7'h00 : decode(nib[d_q]);
    end

    anodes_d   = anodes_d ^ ANODE_OFF;
    segments_d = segments_d ^ SEG_OFF;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      p_q        <= '0;
      d_q        <= '0;
      shadow_q   <= '0;
      anodes_q   <= ANODE_OFF;
      segments_q <= SEG_OFF;
    end else begin
      p_q        <= p_d;
      d_q        <= d_d;
      shadow_q   <= shadow_d;
      anodes_q   <= anodes_d;
      segments_q <= segments_d;
    end
  end

  assign anodes   = anodes_q;
  assign segments = segments_q;

endmodule
`default_nettype wire
